// File: rtl/bd_tag_split_pkg.sv
// bd_tag_split_pkg
// Shared constants for the BD tag splitter: default field widths and the
// leaf codes that identify tag-bearing words.
package bd_tag_split_pkg;

    localparam int NBD_PAYLOAD_W = 32;
    localparam int NBD_CODE_W    = 4;
    localparam int NTAG_W        = 11;
    localparam int NCT_W         = 9;

    localparam int RO_ACC_code   = 11;
    localparam int RO_TAT_code   = 12;

endpackage

// File: rtl/bd_split_slice.sv
// bd_split_slice
// Two-entry skid buffer with a registered output. not_full depends only on
// the stored occupancy, so the upstream accept never combinationally depends
// on the downstream accept.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data, in_push  write data / write request (ignored when full)
//   not_full          buffer can take a word this cycle
//   out_data, out_v   head word (0 when empty) / head valid
//   out_a             downstream accept
module bd_split_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_push,
    output logic         not_full,
    output logic [W-1:0] out_data,
    output logic         out_v,
    input  logic         out_a
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic         push, pop;

    assign not_full = (cnt_q != 2'd2);
    assign out_v    = (cnt_q != 2'd0);
    assign out_data = out_v ? e0_q : '0;
    assign push     = in_push && not_full;
    assign pop      = out_v && out_a;

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        if (pop) begin
            e0_d = e1_q;
        end
        // New word lands in the first slot that is free after this cycle's pop.
        if (push) begin
            if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
                e0_d = in_data;
            end else begin
                e1_d = in_data;
            end
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

endmodule

// File: rtl/bd_tag_split.sv
// bd_tag_split
// Routes decoded BD words: tag words (RO_ACC / RO_TAT) are split into tag and
// count fields on tag_out; all other words pass unmodified to other_out. With
// report_tags set, tag words are also copied to other_out. Each output has its
// own 2-entry skid buffer; a word going to both is accepted only when both
// buffers have room, so it is never written to just one.
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   BD_in_payload/leaf_code/v, BD_in_a input word channel
//   report_tags                        also forward tag words to other_out
//   tag_out_tag/ct/v, tag_out_a        tag channel
//   other_out_payload/leaf_code/v, _a  forwarded-word channel
module bd_tag_split
    import bd_tag_split_pkg::*;
#(
    parameter int NBDpayload = NBD_PAYLOAD_W,
    parameter int NBDcode    = NBD_CODE_W,
    parameter int Ntag       = NTAG_W,
    parameter int Nct        = NCT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NBDpayload-1:0] BD_in_payload,
    input  logic [NBDcode-1:0]    BD_in_leaf_code,
    input  logic                  BD_in_v,
    output logic                  BD_in_a,
    input  logic                  report_tags,
    output logic [Ntag-1:0]       tag_out_tag,
    output logic [Nct-1:0]        tag_out_ct,
    output logic                  tag_out_v,
    input  logic                  tag_out_a,
    output logic [NBDpayload-1:0] other_out_payload,
    output logic [NBDcode-1:0]    other_out_leaf_code,
    output logic                  other_out_v,
    input  logic                  other_out_a
);

    localparam int TW = Ntag + Nct;
    localparam int OW = NBDpayload + NBDcode;

    logic          is_tag, to_other;
    logic          tag_nf, other_nf;
    logic          tag_push, other_push;
    logic [TW-1:0] tag_in, tag_q_out;
    logic [OW-1:0] other_in, other_q_out;

    assign is_tag   = (BD_in_leaf_code == NBDcode'(RO_ACC_code)) ||
                      (BD_in_leaf_code == NBDcode'(RO_TAT_code));
    assign to_other = !is_tag || report_tags;

    // reset gates the accept so nothing is offered while the buffers are held clear.
    assign BD_in_a = reset && BD_in_v && (!is_tag || tag_nf) && (!to_other || other_nf);

    assign tag_push   = BD_in_a && is_tag;
    assign other_push = BD_in_a && to_other;

    assign tag_in   = {BD_in_payload[TW-1:Nct], BD_in_payload[Nct-1:0]};
    assign other_in = {BD_in_payload, BD_in_leaf_code};

    bd_split_slice #(.W(TW)) u_tag_slice (
        .clk      (clk),
        .rst_n    (reset),
        .in_data  (tag_in),
        .in_push  (tag_push),
        .not_full (tag_nf),
        .out_data (tag_q_out),
        .out_v    (tag_out_v),
        .out_a    (tag_out_a)
    );

    bd_split_slice #(.W(OW)) u_other_slice (
        .clk      (clk),
        .rst_n    (reset),
        .in_data  (other_in),
        .in_push  (other_push),
        .not_full (other_nf),
        .out_data (other_q_out),
        .out_v    (other_out_v),
        .out_a    (other_out_a)
    );

    assign tag_out_tag         = tag_q_out[TW-1:Nct];
    assign tag_out_ct          = tag_q_out[Nct-1:0];
    assign other_out_payload   = other_q_out[OW-1:NBDcode];
    assign other_out_leaf_code = other_q_out[NBDcode-1:0];

endmodule

// File: tb/tb_bd_tag_split.sv
module tb_bd_tag_split;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] BD_in_payload;
    logic [3:0]  BD_in_leaf_code;
    logic        BD_in_v;
    logic        BD_in_a;
    logic        report_tags;
    logic [10:0] tag_out_tag;
    logic [8:0]  tag_out_ct;
    logic        tag_out_v;
    logic        tag_out_a;
    logic [31:0] other_out_payload;
    logic [3:0]  other_out_leaf_code;
    logic        other_out_v;
    logic        other_out_a;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bd_tag_split dut (
        .clk                 (clk),
        .reset               (reset),
        .BD_in_payload       (BD_in_payload),
        .BD_in_leaf_code     (BD_in_leaf_code),
        .BD_in_v             (BD_in_v),
        .BD_in_a             (BD_in_a),
        .report_tags         (report_tags),
        .tag_out_tag         (tag_out_tag),
        .tag_out_ct          (tag_out_ct),
        .tag_out_v           (tag_out_v),
        .tag_out_a           (tag_out_a),
        .other_out_payload   (other_out_payload),
        .other_out_leaf_code (other_out_leaf_code),
        .other_out_v         (other_out_v),
        .other_out_a         (other_out_a)
    );

    task automatic drive(input logic v, input logic [3:0] code, input logic [31:0] pay);
        BD_in_v         = v;
        BD_in_leaf_code = code;
        BD_in_payload   = pay;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 4'd0, 32'd0);
        tag_out_a   = 1'b1;
        other_out_a = 1'b1;
        repeat (4) next_cycle();
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        report_tags = 1'b1;
        tag_out_a   = 1'b1;
        other_out_a = 1'b1;
        drive(1'b1, 4'd11, 32'h00123456);
        @(negedge clk);
        n_tests++;
        if (BD_in_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_a got %b exp 0", BD_in_a);
        end
        n_tests++;
        if ({tag_out_v, other_out_v} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_valids got %b exp 00", {tag_out_v, other_out_v});
        end
        n_tests++;
        if ({tag_out_tag, tag_out_ct, other_out_payload, other_out_leaf_code} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h exp 0",
                     {tag_out_tag, tag_out_ct, other_out_payload, other_out_leaf_code});
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({tag_out_v, other_out_v} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_held_valids got %b exp 00", {tag_out_v, other_out_v});
        end
        drive(1'b0, 4'd0, 32'd0);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic test_tag_only();
        report_tags = 1'b0;
        tag_out_a   = 1'b1;
        other_out_a = 1'b1;
        drive(1'b1, 4'd11, 32'h00123456);
        @(negedge clk);
        n_tests++;
        if ({BD_in_a, tag_out_v} !== 2'b10) begin
            n_fail++;
            $display("FAIL tag_only_accept got a=%b v=%b exp a=1 v=0", BD_in_a, tag_out_v);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        n_tests++;
        if ({tag_out_v, tag_out_tag, tag_out_ct} !== {1'b1, 11'h11A, 9'h056}) begin
            n_fail++;
            $display("FAIL tag_only_fields got v=%b tag=%h ct=%h exp v=1 tag=11a ct=056",
                     tag_out_v, tag_out_tag, tag_out_ct);
        end
        n_tests++;
        if (other_out_v !== 1'b0) begin
            n_fail++;
            $display("FAIL tag_only_other got %b exp 0", other_out_v);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (tag_out_v !== 1'b0) begin
            n_fail++;
            $display("FAIL tag_only_once got %b exp 0", tag_out_v);
        end
        next_cycle();
    endtask

    task automatic test_report_tags();
        report_tags = 1'b1;
        tag_out_a   = 1'b1;
        other_out_a = 1'b1;
        drive(1'b1, 4'd11, 32'h00123456);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        n_tests++;
        if ({tag_out_v, tag_out_tag, tag_out_ct} !== {1'b1, 11'h11A, 9'h056}) begin
            n_fail++;
            $display("FAIL report_tag_fields got v=%b tag=%h ct=%h exp v=1 tag=11a ct=056",
                     tag_out_v, tag_out_tag, tag_out_ct);
        end
        n_tests++;
        if ({other_out_v, other_out_payload, other_out_leaf_code} !== {1'b1, 32'h00123456, 4'd11}) begin
            n_fail++;
            $display("FAIL report_other got v=%b pay=%h leaf=%0d exp v=1 pay=00123456 leaf=11",
                     other_out_v, other_out_payload, other_out_leaf_code);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({tag_out_v, other_out_v} !== 2'b00) begin
            n_fail++;
            $display("FAIL report_once got %b exp 00", {tag_out_v, other_out_v});
        end
        next_cycle();
    endtask

    task automatic test_other();
        report_tags = 1'b0;
        tag_out_a   = 1'b1;
        other_out_a = 1'b1;
        drive(1'b1, 4'd3, 32'hDEADBEEF);
        next_cycle();
        drive(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        n_tests++;
        if ({other_out_v, other_out_payload, other_out_leaf_code} !== {1'b1, 32'hDEADBEEF, 4'd3}) begin
            n_fail++;
            $display("FAIL other_fwd got v=%b pay=%h leaf=%0d exp v=1 pay=deadbeef leaf=3",
                     other_out_v, other_out_payload, other_out_leaf_code);
        end
        n_tests++;
        if ({tag_out_v, tag_out_tag, tag_out_ct} !== 21'd0) begin
            n_fail++;
            $display("FAIL other_no_tag got v=%b tag=%h ct=%h exp all 0",
                     tag_out_v, tag_out_tag, tag_out_ct);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] sent[$];
        logic [31:0] w;
        int idx  = 0;
        int ocnt = 0;
        int tcnt = 0;
        int oext = 0;
        drain();
        report_tags = 1'b1;
        tag_out_a   = 1'b0;
        other_out_a = 1'b1;
        for (int c = 0; c < 6; c++) begin
            w = 32'h10000000 + 32'(idx) * 32'h00000203;
            drive(1'b1, 4'd11, w);
            @(negedge clk);
            if (other_out_v && other_out_a) begin
                n_tests++;
                if (ocnt >= sent.size() || other_out_payload !== sent[ocnt]) begin
                    n_fail++;
                    $display("FAIL stall_other_order got %h at index %0d", other_out_payload, ocnt);
                end
                ocnt++;
            end
            if (BD_in_a) begin
                sent.push_back(w);
                idx++;
            end
            next_cycle();
        end
        n_tests++;
        if (sent.size() != 2) begin
            n_fail++;
            $display("FAIL stall_accepted got %0d exp 2", sent.size());
        end
        n_tests++;
        if (ocnt != 2) begin
            n_fail++;
            $display("FAIL stall_other_count got %0d exp 2", ocnt);
        end
        drive(1'b0, 4'd0, 32'd0);
        tag_out_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (tag_out_v) begin
                w = (tcnt < sent.size()) ? sent[tcnt] : 32'hFFFFFFFF;
                n_tests++;
                if ({tag_out_tag, tag_out_ct} !== {w[19:9], w[8:0]}) begin
                    n_fail++;
                    $display("FAIL stall_tag_order got tag=%h ct=%h exp tag=%h ct=%h",
                             tag_out_tag, tag_out_ct, w[19:9], w[8:0]);
                end
                tcnt++;
            end
            if (other_out_v) oext++;
            next_cycle();
        end
        n_tests++;
        if (tcnt != 2) begin
            n_fail++;
            $display("FAIL stall_tag_count got %0d exp 2", tcnt);
        end
        n_tests++;
        if (oext != 0) begin
            n_fail++;
            $display("FAIL stall_other_dup got %0d extra exp 0", oext);
        end
    endtask

    task automatic test_random();
        logic [19:0] tq[$];
        logic [35:0] oq[$];
        logic [31:0] pay;
        logic [3:0]  code;
        logic        v, is_t, to_o, exp_a;
        logic [20:0] exp_t;
        logic [36:0] exp_o;
        int          r;
        drain();
        report_tags = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 50 == 0) report_tags = ~report_tags;
            v   = ($urandom_range(0, 3) != 0);
            r   = $urandom_range(0, 3);
            code = (r == 0) ? 4'd11 : (r == 1) ? 4'd12 : 4'($urandom_range(0, 15));
            pay = $urandom;
            drive(v, code, pay);
            tag_out_a   = ($urandom_range(0, 3) != 0);
            other_out_a = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            is_t  = (code == 4'd11) || (code == 4'd12);
            to_o  = !is_t || report_tags;
            exp_a = v && (!is_t || tq.size() < 2) && (!to_o || oq.size() < 2);
            exp_t = (tq.size() > 0) ? {1'b1, tq[0]} : 21'd0;
            exp_o = (oq.size() > 0) ? {1'b1, oq[0]} : 37'd0;
            n_tests++;
            if (BD_in_a !== exp_a) begin
                n_fail++;
                $display("FAIL rand_in_a cyc %0d got %b exp %b", cyc, BD_in_a, exp_a);
            end
            n_tests++;
            if ({tag_out_v, tag_out_tag, tag_out_ct} !== exp_t) begin
                n_fail++;
                $display("FAIL rand_tag cyc %0d got %h exp %h", cyc,
                         {tag_out_v, tag_out_tag, tag_out_ct}, exp_t);
            end
            n_tests++;
            if ({other_out_v, other_out_payload, other_out_leaf_code} !== exp_o) begin
                n_fail++;
                $display("FAIL rand_other cyc %0d got %h exp %h", cyc,
                         {other_out_v, other_out_payload, other_out_leaf_code}, exp_o);
            end
            if (tq.size() > 0 && tag_out_a) void'(tq.pop_front());
            if (oq.size() > 0 && other_out_a) void'(oq.pop_front());
            if (exp_a) begin
                if (is_t) tq.push_back({pay[19:9], pay[8:0]});
                if (to_o) oq.push_back({pay, code});
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        drain();
        report_tags = 1'b1;
        tag_out_a   = 1'b0;
        other_out_a = 1'b0;
        drive(1'b1, 4'd11, 32'hAAAA1111);
        repeat (3) next_cycle();
        @(negedge clk);
        n_tests++;
        if ({tag_out_v, other_out_v, BD_in_a} !== 3'b110) begin
            n_fail++;
            $display("FAIL rmid_full got %b exp 110", {tag_out_v, other_out_v, BD_in_a});
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({tag_out_v, other_out_v, BD_in_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_clear got %b exp 000", {tag_out_v, other_out_v, BD_in_a});
        end
        n_tests++;
        if ({tag_out_tag, tag_out_ct, other_out_payload, other_out_leaf_code} !== 56'd0) begin
            n_fail++;
            $display("FAIL rmid_data got %h exp 0",
                     {tag_out_tag, tag_out_ct, other_out_payload, other_out_leaf_code});
        end
        next_cycle();
        reset       = 1'b1;
        report_tags = 1'b0;
        tag_out_a   = 1'b1;
        other_out_a = 1'b1;
        drive(1'b1, 4'd12, 32'h000FFE03);
        @(negedge clk);
        n_tests++;
        if (BD_in_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_accept got %b exp 1", BD_in_a);
        end
        next_cycle();
        drive(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        n_tests++;
        if ({tag_out_v, tag_out_tag, tag_out_ct, other_out_v} !== {1'b1, 11'h7FF, 9'h003, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_first got v=%b tag=%h ct=%h ov=%b exp v=1 tag=7ff ct=003 ov=0",
                     tag_out_v, tag_out_tag, tag_out_ct, other_out_v);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({tag_out_v, other_out_v} !== 2'b00) begin
            n_fail++;
            $display("FAIL rmid_no_stale got %b exp 00", {tag_out_v, other_out_v});
        end
    endtask

    initial begin
        test_reset();
        test_tag_only();
        test_report_tags();
        test_other();
        test_back_to_back_stall();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
